// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default timing
// constants and a parameter-legality helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        HOLD   = 2'd1,
        STEP   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_NUM_STAGES = 3;
    localparam int DEF_MIN_ASSERT = 8;
    localparam int DEF_STAGE_GAP  = 16;
    localparam int DEF_CNT_W      = 8;

    // The counter must reach both terminal values without wrapping.
    function automatic bit params_ok(input int num_stages, input int min_assert,
                                     input int stage_gap, input int cnt_w);
        int mx;
        mx = (min_assert > stage_gap) ? min_assert : stage_gap;
        return (num_stages >= 1) && (num_stages <= 8) &&
               (min_assert >= 1) && (stage_gap >= 1) &&
               (cnt_w >= 1) && (cnt_w < 31) && ((1 << cnt_w) > mx);
    endfunction

endpackage

// File: rtl/reset_seq.sv
// Sequenced release of NUM_STAGES active-low domain resets after the system
// reset request drops. Optional software re-sequence input: RESET_SEQ_SWRST_EN.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int MIN_ASSERT = DEF_MIN_ASSERT,
    parameter int STAGE_GAP  = DEF_STAGE_GAP,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rst_req_in,
`ifdef RESET_SEQ_SWRST_EN
    input  logic                  sw_rst_req,
`endif
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  all_released,
    output logic                  busy
);

    localparam int SIDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [SIDX_W-1:0] IDX_LAST  = SIDX_W'(NUM_STAGES - 1);

    if (!params_ok(NUM_STAGES, MIN_ASSERT, STAGE_GAP, CNT_W)) begin : g_bad_params
        $error("reset_seq: illegal parameter combination");
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [SIDX_W-1:0] stage_idx;
    logic              seen_req;
    logic              sw_req;
    logic              abort_req;
    logic              start_req;

`ifdef RESET_SEQ_SWRST_EN
    assign sw_req = sw_rst_req;
`else
    assign sw_req = 1'b0;
`endif

    assign abort_req = rst_req_in | sw_req;
    // seen_req keeps the outputs asserted until the generator has produced a pulse.
    assign start_req = !rst_req_in && (seen_req || sw_req);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ASSERT;
            cnt          <= '0;
            stage_idx    <= '0;
            seen_req     <= 1'b0;
            rst_n_out    <= '0;
            all_released <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (rst_req_in)
                seen_req <= 1'b1;

            if (state != ASSERT && abort_req) begin
                state        <= ASSERT;
                cnt          <= '0;
                stage_idx    <= '0;
                rst_n_out    <= '0;
                all_released <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    ASSERT: begin
                        cnt          <= '0;
                        stage_idx    <= '0;
                        rst_n_out    <= '0;
                        all_released <= 1'b0;
                        busy         <= 1'b0;
                        if (start_req) begin
                            state <= HOLD;
                            busy  <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state     <= STEP;
                            cnt       <= '0;
                            stage_idx <= '0;
                            rst_n_out <= NUM_STAGES'(1);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STEP: begin
                        if (stage_idx == IDX_LAST) begin
                            state        <= DONE;
                            cnt          <= '0;
                            all_released <= 1'b1;
                            busy         <= 1'b0;
                        end else if (cnt == GAP_LAST) begin
                            // Shifting in a one keeps the release mask a thermometer code.
                            rst_n_out <= (rst_n_out << 1) | NUM_STAGES'(1);
                            stage_idx <= stage_idx + SIDX_W'(1);
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DONE: begin
                        cnt <= '0;
                    end
                    default: state <= ASSERT;
                endcase
            end
        end
    end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Downstream stage of the system reset generator.
- Consumes its active-high, stretched `peripheral_reset` pulse on `rst_req_in`.
- Releases NUM_STAGES active-low domain resets in fixed order (e.g. bus/interconnect, memories, peripherals, core), with a programmable gap between releases.
- Guarantees no domain leaves reset before its predecessor, and re-asserts everything immediately on any new request.

Parameters:
- NUM_STAGES, 3, number of sequenced reset outputs (1..8); bit 0 is released first.
- MIN_ASSERT, 8, cycles all outputs stay asserted after `rst_req_in` deasserts (>=1).
- STAGE_GAP, 16, cycles between consecutive stage releases (>=1).
- CNT_W, 8, counter width; must satisfy 2^CNT_W > max(MIN_ASSERT, STAGE_GAP).

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst_n, input, 1, synchronous active-low reset.
- rst_req_in, input, 1, active-high reset request from the reset generator; synchronous to clk.
- rst_n_out, output, NUM_STAGES, per-domain active-low resets; bit k is released k-th.
- all_released, output, 1, high when every stage is released.
- busy, output, 1, high in HOLD or STEP.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ASSERT, rst_n_out=0, all_released=0, busy=0.
  - cnt=0, stage_idx=0, seen_req=0.
- All outputs are registered. No combinational path from input to output.
- seen_req: set on any edge with rst_req_in=1; cleared only by rst_n. This blocks release before the generator has produced its first pulse (i.e. before clock lock).
- ASSERT:
  - rst_n_out=0, cnt=0.
  - Go to HOLD on the first edge with rst_req_in=0 and seen_req=1. Call that edge T.
- HOLD:
  - cnt increments each cycle.
  - When cnt==MIN_ASSERT-1: go to STEP, set rst_n_out[0]=1, cnt=0, stage_idx=0.
  - Result: stage 0 releases at edge T+MIN_ASSERT.
- STEP:
  - cnt increments each cycle.
  - When cnt==STAGE_GAP-1 and stage_idx<NUM_STAGES-1: set rst_n_out[stage_idx+1]=1, stage_idx++, cnt=0.
  - Result: stage k releases at edge T+MIN_ASSERT+k*STAGE_GAP.
  - When stage_idx==NUM_STAGES-1: go to DONE on the next edge; all_released=1 from that edge.
  - NUM_STAGES=1 therefore gives all_released at T+MIN_ASSERT+1.
- DONE: hold all outputs at 1 until a new request.
- Abort:
  - rst_req_in=1 sampled in HOLD, STEP or DONE goes to ASSERT at that edge.
  - That same edge sets rst_n_out=0, all_released=0, busy=0, cnt=0, stage_idx=0. Latency is one cycle.
  - The full sequence (including MIN_ASSERT) restarts after the request drops.
- rst_req_in=1 held in ASSERT: remain in ASSERT indefinitely.
- rst_n_out is monotonic within a sequence. A set bit is never cleared except by abort or rst_n, and bit k+1 is never 1 while bit k is 0.
- Counter never wraps; it is compared against parameters and cleared at each transition.

Optional Feature:
- Macro: RESET_SEQ_SWRST_EN.
- When defined:
  - Adds input `sw_rst_req` (1 bit, single-cycle pulse from a control register).
  - In HOLD, STEP or DONE it acts as a one-cycle rst_req_in: abort to ASSERT at that edge.
  - In ASSERT it acts as the falling request: go to HOLD on the next edge, without requiring seen_req.
  - Net effect: a software-initiated full re-sequence.
- When undefined: the port is absent and the behaviour is as above.

Decomposition:
- Package reset_seq_pkg:
  - state encoding constants ASSERT=2'd0, HOLD=2'd1, STEP=2'd2, DONE=2'd3.
  - default MIN_ASSERT/STAGE_GAP constants.
  - parameter-legality check helper.
- Single flat module, one shared counter; no sub-module is warranted.

Test Plan:
- Defaults; rst_n low 4 cycles, rst_req_in pulsed high cycles 10-20, falling sampled at edge T → rst_n_out: 000→001 at T+8, 011 at T+24, 111 at T+40; all_released=1 at T+41; busy high T..T+40.
- rst_req_in held 0 from reset for 200 cycles → rst_n_out stays 000, all_released=0 (seen_req gate).
- Re-pulse rst_req_in at T+30 (stage0/1 released) → rst_n_out=000 at T+30 edge; a new fall at T' gives stage0 at T'+8, not earlier.
- rst_req_in pulse during DONE → all outputs 0 next edge; identical release timing repeats.
- rst_n asserted at T+20 mid-STEP → all outputs 0 next edge, seen_req cleared; nothing releases until a new request pulse.
- RESET_SEQ_SWRST_EN defined: sw_rst_req pulse in DONE → rst_n_out=000 next edge; with rst_req_in=0, stage0 releases 8 cycles after ASSERT→HOLD, and all_released follows at the same offsets as the first test.
